// File: rtl/rename_pkg.sv
// Shared rename/scheduler types: physical register tags, renamed instructions,
// branch resolution and the issue-queue entry.
package rename_pkg;

  localparam int unsigned P_IDX_W  = 6;
  localparam int unsigned IQ_DEPTH = 8;

  typedef struct packed {
    logic               valid;
    logic               ready;
    logic [P_IDX_W-1:0] idx;
  } p_reg_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] op;
    p_reg_t     rs1;
    p_reg_t     rs2;
    p_reg_t     rd;
  } rinstr_t;

  typedef struct packed {
    logic valid;
    logic hit;
  } br_result_t;

  typedef struct packed {
    rinstr_t instr;
    logic    spec;
  } iq_entry_t;

  // p0 is hardwired and never waits on a producer.
  function automatic logic src_ready(p_reg_t src);
    return src.ready | ~src.valid | (src.idx == '0);
  endfunction

  function automatic p_reg_t wake_src(p_reg_t src, p_reg_t wakeup);
    p_reg_t res;
    res = src;
    if (wakeup.valid && (wakeup.idx != '0) && src.valid && (src.idx == wakeup.idx)) begin
      res.ready = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/issue_queue_select.sv
// Oldest-first grant: lowest-index eligible entry wins, returned as one-hot and index.
module iq_select #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] eligible_i,
  output logic [DEPTH-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (eligible_i[i] && (grant_o == '0)) begin
        grant_o[i] = 1'b1;
        idx_o      = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Collapsing age-ordered issue queue: wakeup tracking, oldest-ready select and
// branch squash with survivor re-compaction.
module issue_queue
  import rename_pkg::*;
#(
  parameter int unsigned DEPTH = IQ_DEPTH,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst_ni,
  input  rinstr_t    rinstr_i,
  input  logic       rspec_i,
  input  p_reg_t     wakeup_i,
  input  br_result_t br_result_i,
  output rinstr_t    issue_o,
  input  logic       issue_ready_i,
  output logic       iq_full_o,
  output logic       iq_empty_o
);

  iq_entry_t [DEPTH-1:0] entries_q, entries_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DEPTH-1:0]      eligible, grant, keep;
  logic [IDX_W-1:0]      grant_idx;
  logic                  squash, resolve_hit, issue_fire, alloc;

  assign squash      = br_result_i.valid & ~br_result_i.hit;
  assign resolve_hit = br_result_i.valid & br_result_i.hit;

  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      eligible[i] = entries_q[i].instr.valid
                  & src_ready(entries_q[i].instr.rs1)
                  & src_ready(entries_q[i].instr.rs2)
                  & ~(squash & entries_q[i].spec);
    end
  end

  iq_select #(
    .DEPTH(DEPTH)
  ) u_select (
    .eligible_i(eligible),
    .grant_o   (grant),
    .idx_o     (grant_idx)
  );

  assign issue_o    = (|eligible) ? entries_q[grant_idx].instr : '0;
  assign issue_fire = issue_o.valid & issue_ready_i;

  assign iq_full_o  = (count_q == CNT_W'(DEPTH));
  assign iq_empty_o = (count_q == '0);

  // A speculative push is dropped in the same cycle its branch mispredicts.
  assign alloc = rinstr_i.valid & ~iq_full_o & ~(squash & rspec_i);

  always_comb begin
    keep = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      keep[i] = entries_q[i].instr.valid
              & ~(issue_fire & grant[i])
              & ~(squash & entries_q[i].spec);
    end
  end

  // Each survivor moves to the number of survivors older than itself; the new
  // instruction lands right behind the last survivor.
  always_comb begin
    logic [CNT_W-1:0] dst;
    iq_entry_t        ent;
    entries_d = '0;
    dst       = '0;
    ent       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (keep[i]) begin
        ent           = entries_q[i];
        ent.instr.rs1 = wake_src(entries_q[i].instr.rs1, wakeup_i);
        ent.instr.rs2 = wake_src(entries_q[i].instr.rs2, wakeup_i);
        if (resolve_hit) begin
          ent.spec = 1'b0;
        end
        entries_d[dst[IDX_W-1:0]] = ent;
        dst = dst + 1'b1;
      end
    end
    count_d = dst;
    if (alloc) begin
      ent           = '0;
      ent.instr     = rinstr_i;
      ent.instr.rs1 = wake_src(rinstr_i.rs1, wakeup_i);
      ent.instr.rs2 = wake_src(rinstr_i.rs2, wakeup_i);
      ent.spec      = rspec_i & ~resolve_hit;
      entries_d[dst[IDX_W-1:0]] = ent;
      count_d = dst + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      entries_q <= '0;
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      count_q   <= count_d;
    end
  end

  // Upstream must honour iq_full_o; a push while full is dropped.
  assert property (@(posedge clk) disable iff (!rst_ni) !(rinstr_i.valid && iq_full_o));

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: queue-based reference model plus directed
// scenarios with literal expectations, then a randomized run.
module tb_issue_queue;
  import rename_pkg::*;

  localparam int DEPTH = int'(IQ_DEPTH);

  logic       clk = 1'b0;
  logic       rst_ni;
  rinstr_t    rinstr_i;
  logic       rspec_i;
  p_reg_t     wakeup_i;
  br_result_t br_result_i;
  rinstr_t    issue_o;
  logic       issue_ready_i;
  logic       iq_full_o;
  logic       iq_empty_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    rinstr_t ins;
    bit      spec;
  } m_ent_t;

  m_ent_t mq[$];

  always #5 clk = ~clk;

  issue_queue #(
    .DEPTH(IQ_DEPTH)
  ) dut (
    .clk          (clk),
    .rst_ni       (rst_ni),
    .rinstr_i     (rinstr_i),
    .rspec_i      (rspec_i),
    .wakeup_i     (wakeup_i),
    .br_result_i  (br_result_i),
    .issue_o      (issue_o),
    .issue_ready_i(issue_ready_i),
    .iq_full_o    (iq_full_o),
    .iq_empty_o   (iq_empty_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rinstr_t mk(int op, bit v1, bit r1, int i1, bit v2, bit r2, int i2, int rd);
    rinstr_t r;
    r           = '0;
    r.valid     = 1'b1;
    r.op        = 8'(op);
    r.rs1.valid = v1;
    r.rs1.ready = r1;
    r.rs1.idx   = P_IDX_W'(i1);
    r.rs2.valid = v2;
    r.rs2.ready = r2;
    r.rs2.idx   = P_IDX_W'(i2);
    r.rd.valid  = 1'b1;
    r.rd.idx    = P_IDX_W'(rd);
    return r;
  endfunction

  function automatic bit m_rdy(p_reg_t p);
    return p.ready || !p.valid || (p.idx == 0);
  endfunction

  function automatic p_reg_t m_wake(p_reg_t p);
    if (wakeup_i.valid && wakeup_i.idx != 0 && p.valid && p.idx == wakeup_i.idx) p.ready = 1'b1;
    return p;
  endfunction

  // Oldest ready entry that is not being squashed right now.
  function automatic int m_sel();
    bit sq;
    sq = br_result_i.valid && !br_result_i.hit;
    for (int i = 0; i < mq.size(); i++) begin
      if (m_rdy(mq[i].ins.rs1) && m_rdy(mq[i].ins.rs2) && !(sq && mq[i].spec)) return i;
    end
    return -1;
  endfunction

  task automatic idle_inputs();
    rinstr_i    = '0;
    rspec_i     = 1'b0;
    wakeup_i    = '0;
    br_result_i = '0;
  endtask

  // Compare outputs against the model, advance the model, cross one posedge.
  task automatic cyc();
    int      sel;
    rinstr_t exp;
    bit      sq, hit, fire, full_now;
    m_ent_t  kept[$];
    m_ent_t  e;
    #1;
    sel = m_sel();
    exp = (sel >= 0) ? mq[sel].ins : '0;
    check("issue_o", 64'(issue_o), 64'(exp));
    check("iq_full_o", 64'(iq_full_o), 64'(mq.size() == DEPTH));
    check("iq_empty_o", 64'(iq_empty_o), 64'(mq.size() == 0));
    sq       = br_result_i.valid && !br_result_i.hit;
    hit      = br_result_i.valid && br_result_i.hit;
    full_now = (mq.size() == DEPTH);
    fire     = (sel >= 0) && issue_ready_i;
    if (fire) mq.delete(sel);
    if (sq) begin
      foreach (mq[i]) if (!mq[i].spec) kept.push_back(mq[i]);
      mq = kept;
    end
    foreach (mq[i]) begin
      if (hit) mq[i].spec = 1'b0;
      mq[i].ins.rs1 = m_wake(mq[i].ins.rs1);
      mq[i].ins.rs2 = m_wake(mq[i].ins.rs2);
    end
    if (rinstr_i.valid && !full_now && !(sq && rspec_i)) begin
      e.ins     = rinstr_i;
      e.ins.rs1 = m_wake(rinstr_i.rs1);
      e.ins.rs2 = m_wake(rinstr_i.rs2);
      e.spec    = rspec_i && !hit;
      mq.push_back(e);
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #2;
    check("rst_issue_o", 64'(issue_o), 64'd0);
    check("rst_empty", 64'(iq_empty_o), 64'd1);
    check("rst_full", 64'(iq_full_o), 64'd0);
    mq.delete();
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rinstr_t t6;
    rst_ni        = 1'b1;
    issue_ready_i = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    do_reset();

    // 1: ready instruction issues the cycle after allocation.
    rinstr_i = mk(1, 1, 1, 5, 0, 0, 0, 40);
    cyc();
    #1;
    check("t1_valid", 64'(issue_o.valid), 64'd1);
    check("t1_rd", 64'(issue_o.rd.idx), 64'd40);
    cyc();
    #1;
    check("t1_empty", 64'(iq_empty_o), 64'd1);

    // 2: younger ready instruction overtakes; wakeup releases the older one.
    do_reset();
    rinstr_i = mk(2, 1, 0, 33, 0, 0, 0, 41);
    cyc();
    rinstr_i = mk(3, 1, 1, 7, 1, 0, 0, 42);
    cyc();
    #1;
    check("t2_b_first", 64'(issue_o.rd.idx), 64'd42);
    cyc();
    wakeup_i = '{valid: 1'b1, ready: 1'b0, idx: P_IDX_W'(33)};
    #1;
    check("t2_a_waits", 64'(issue_o.valid), 64'd0);
    cyc();
    #1;
    check("t2_a_valid", 64'(issue_o.valid), 64'd1);
    check("t2_a_rd", 64'(issue_o.rd.idx), 64'd41);
    cyc();

    // 3: fill, wake everything, drain in push order.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      rinstr_i = mk(i, 1, 0, 10 + i, 0, 0, 0, 20 + i);
      cyc();
    end
    #1;
    check("t3_full", 64'(iq_full_o), 64'd1);
    issue_ready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      wakeup_i = '{valid: 1'b1, ready: 1'b0, idx: P_IDX_W'(10 + i)};
      cyc();
    end
    issue_ready_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      check("t3_order", 64'(issue_o.rd.idx), 64'(20 + i));
      cyc();
    end
    #1;
    check("t3_empty", 64'(iq_empty_o), 64'd1);

    // 4: wakeup bypassed into the allocating instruction.
    do_reset();
    rinstr_i = mk(4, 0, 0, 0, 1, 0, 41, 43);
    wakeup_i = '{valid: 1'b1, ready: 1'b0, idx: P_IDX_W'(41)};
    cyc();
    #1;
    check("t4_valid", 64'(issue_o.valid), 64'd1);
    check("t4_rd", 64'(issue_o.rd.idx), 64'd43);
    cyc();

    // 5a: mispredict squashes spec entries, which are masked in the resolve cycle.
    do_reset();
    issue_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rinstr_i = (i < 2) ? mk(i, 1, 0, 50, 0, 0, 0, 44 + i) : mk(i, 1, 1, 9, 0, 0, 0, 44 + i);
      rspec_i  = (i >= 2);
      cyc();
    end
    issue_ready_i = 1'b1;
    br_result_i   = '{valid: 1'b1, hit: 1'b0};
    #1;
    check("t5_masked", 64'(issue_o.valid), 64'd0);
    cyc();
    #1;
    check("t5_miss_count", 64'(dut.count_q), 64'd2);
    check("t5_model_count", 64'(mq.size()), 64'd2);
    wakeup_i = '{valid: 1'b1, ready: 1'b0, idx: P_IDX_W'(50)};
    cyc();
    cyc();
    cyc();

    // 5b: correct prediction keeps everything and clears the spec bits.
    do_reset();
    issue_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rinstr_i = (i < 2) ? mk(i, 1, 0, 50, 0, 0, 0, 44 + i) : mk(i, 1, 1, 9, 0, 0, 0, 44 + i);
      rspec_i  = (i >= 2);
      cyc();
    end
    br_result_i = '{valid: 1'b1, hit: 1'b1};
    cyc();
    #1;
    check("t5_hit_count", 64'(dut.count_q), 64'd5);
    for (int i = 0; i < 5; i++) check("t5_spec_clear", 64'(dut.entries_q[i].spec), 64'd0);
    issue_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) cyc();

    // 6: issue_o held while execute stalls; async reset clears it at once.
    do_reset();
    issue_ready_i = 1'b0;
    t6            = mk(6, 1, 1, 3, 1, 1, 4, 49);
    rinstr_i      = t6;
    cyc();
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t6_hold", 64'(issue_o), 64'(t6));
      cyc();
    end
    do_reset();

    // Randomized run against the model.
    for (int n = 0; n < 3000; n++) begin
      issue_ready_i = ($urandom_range(3) != 0);
      if (mq.size() < DEPTH && $urandom_range(1) == 1) begin
        rinstr_i = mk($urandom_range(255),
                      $urandom_range(1), $urandom_range(3) == 0, $urandom_range(7),
                      $urandom_range(1), $urandom_range(3) == 0, $urandom_range(7),
                      $urandom_range(63));
        rspec_i  = ($urandom_range(9) < 3);
      end
      if ($urandom_range(9) < 4) begin
        wakeup_i = '{valid: 1'b1, ready: 1'b0, idx: P_IDX_W'($urandom_range(7))};
      end
      if ($urandom_range(19) == 0) begin
        br_result_i = '{valid: 1'b1, hit: $urandom_range(1)};
      end
      if ($urandom_range(499) == 0) begin
        idle_inputs();
        do_reset();
      end else begin
        cyc();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
